// File: rtl/id_ex_stage.sv
// id_ex_stage: one-slot ID/EX pipeline register with load-use stall, flush and ready/valid handshake.
// Optional macro WB_BYPASS_EN forwards the write-back bus into the captured operands.
module id_ex_stage #(
    parameter int DATA_W  = 32,
    parameter int ALUOP_W = 4
) (
    input  logic               Clk,
    input  logic               Rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DATA_W-1:0]  BusA,
    input  logic [DATA_W-1:0]  BusB,
    input  logic [4:0]         RA,
    input  logic [4:0]         RB,
    input  logic [4:0]         Rd,
    input  logic [DATA_W-1:0]  Imm,
    input  logic [ALUOP_W-1:0] ALUOp,
    input  logic               ALUSrc,
    input  logic               MemRead,
    input  logic               MemWrite,
    input  logic               RegWrite,
    input  logic               MemToReg,
    input  logic               WB_RegWr,
    input  logic [4:0]         WB_RW,
    input  logic [DATA_W-1:0]  WB_BusW,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  ex_A,
    output logic [DATA_W-1:0]  ex_B,
    output logic [DATA_W-1:0]  ex_Imm,
    output logic [4:0]         ex_RA,
    output logic [4:0]         ex_RB,
    output logic [4:0]         ex_Rd,
    output logic [ALUOP_W-1:0] ex_ALUOp,
    output logic               ex_ALUSrc,
    output logic               ex_MemRead,
    output logic               ex_MemWrite,
    output logic               ex_RegWrite,
    output logic               ex_MemToReg
);
    logic              advance, load_use, capture;
    logic [DATA_W-1:0] a_nxt, b_nxt;
    assign advance  = !out_valid || out_ready;
    assign load_use = out_valid && ex_MemRead && ex_Rd != 5'd0 && (ex_Rd == RA || ex_Rd == RB);
    assign in_ready = advance && !load_use;
    assign capture  = in_valid && !load_use && !flush;
`ifdef WB_BYPASS_EN
    assign a_nxt = (WB_RegWr && WB_RW != 5'd0 && WB_RW == RA) ? WB_BusW : BusA;
    assign b_nxt = (WB_RegWr && WB_RW != 5'd0 && WB_RW == RB) ? WB_BusW : BusB;
`else
    logic unused_wb;
    assign unused_wb = ^{WB_RegWr, WB_RW, WB_BusW};
    assign a_nxt = BusA;
    assign b_nxt = BusB;
`endif
    // Slot register: load a captured instruction or a bubble on advance, else hold.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            out_valid   <= 1'b0;
            ex_A        <= '0;
            ex_B        <= '0;
            ex_Imm      <= '0;
            ex_RA       <= '0;
            ex_RB       <= '0;
            ex_Rd       <= '0;
            ex_ALUOp    <= '0;
            ex_ALUSrc   <= 1'b0;
            ex_MemRead  <= 1'b0;
            ex_MemWrite <= 1'b0;
            ex_RegWrite <= 1'b0;
            ex_MemToReg <= 1'b0;
        end else if (advance) begin
            out_valid   <= capture;
            ex_A        <= a_nxt;
            ex_B        <= b_nxt;
            ex_Imm      <= Imm;
            ex_RA       <= RA;
            ex_RB       <= RB;
            ex_Rd       <= Rd;
            ex_ALUOp    <= capture ? ALUOp : '0;
            ex_ALUSrc   <= capture && ALUSrc;
            ex_MemRead  <= capture && MemRead;
            ex_MemWrite <= capture && MemWrite;
            ex_RegWrite <= capture && RegWrite;
            ex_MemToReg <= capture && MemToReg;
        end
    end
endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have parameter DATA_W, default 32, operand/immediate width.
REQ-002 SHALL have parameter ALUOP_W, default 4, ALU opcode width.
REQ-003 Clk  input  1  single clock; all state updates on posedge Clk.
REQ-004 Rst_n  input  1  reset; asynchronous, active-low.
REQ-005 in_valid  input  1  decode presents an instruction.
REQ-006 in_ready  output  1  stage accepts the decode instruction this cycle.
REQ-007 BusA, BusB  input  DATA_W each  register-file read data for RA, RB.
REQ-008 RA, RB, Rd  input  5 each  source and destination register addresses.
REQ-009 Imm  input  DATA_W  sign-extended immediate.
REQ-010 ALUOp  input  ALUOP_W; ALUSrc, MemRead, MemWrite, RegWrite, MemToReg  input  1 each  decode controls.
REQ-011 WB_RegWr  input  1, WB_RW  input  5, WB_BusW  input  DATA_W  write-back port, same values driven to the register file.
REQ-012 flush  input  1  kill the instruction being captured this cycle.
REQ-013 out_valid  output  1; out_ready  input  1  handshake to the execute stage.
REQ-014 ex_A, ex_B, ex_Imm  output  DATA_W; ex_RA, ex_RB, ex_Rd  output  5; ex_ALUOp, ex_ALUSrc, ex_MemRead, ex_MemWrite, ex_RegWrite, ex_MemToReg  output  registered copies.

Function
REQ-015 Stage SHALL be one register slot; latency decode-to-execute exactly 1 cycle.
REQ-016 advance = !out_valid || out_ready; registers SHALL load only when advance=1, otherwise hold all outputs.
REQ-017 load_use = out_valid && ex_MemRead && ex_Rd!=0 && (ex_Rd==RA || ex_Rd==RB).
REQ-018 in_ready SHALL equal advance && !load_use, combinationally.
REQ-019 On advance with load_use=1: SHALL load a bubble (out_valid=0, ex_RegWrite=0, ex_MemRead=0, ex_MemWrite=0); decode instruction not consumed.
REQ-020 On advance with in_valid=1, load_use=0, flush=0: SHALL capture all inputs, out_valid=1.
REQ-021 On advance with in_valid=0: SHALL load a bubble.
REQ-022 flush=1 with advance=1 SHALL load a bubble regardless of in_valid/load_use; in_ready still reports REQ-018 value.
REQ-023 flush=1 with advance=0 SHALL be ignored (held instruction is already past decode).
REQ-024 Bubble SHALL clear all control outputs; data outputs unspecified.
REQ-025 Register 0 SHALL never trigger load_use or bypass.

Reset
REQ-026 Rst_n low SHALL asynchronously force out_valid=0 and every ex_* output to 0.
REQ-027 Reset mid-stall SHALL drop the held instruction; first cycle after release in_ready=1.

Configuration
REQ-028 Macro WB_BYPASS_EN: when defined, on capture ex_A SHALL take WB_BusW if WB_RegWr && WB_RW!=0 && WB_RW==RA, else BusA; ex_B likewise with RB/BusB.
REQ-029 Without WB_BYPASS_EN, ex_A/ex_B SHALL capture BusA/BusB unmodified; WB_* ports remain present and unused.

Verification
REQ-030 Reset: Rst_n=0 asynchronously mid-cycle with out_valid=1 -> out_valid=0, all ex_*=0 before next edge.
REQ-031 Pass-through: in_valid=1, RA=3, BusA=0x11, Imm=0xFFFFFFF0, out_ready=1 -> next cycle out_valid=1, ex_A=0x11, ex_Imm=0xFFFFFFF0.
REQ-032 Load-use: held MemRead, ex_Rd=5; incoming RA=5 -> in_ready=0, one bubble inserted, instruction captured following cycle; same with ex_Rd=0 -> no stall.
REQ-033 Backpressure: out_ready=0 for 3 cycles -> outputs frozen, in_ready=0; out_ready=1 -> next instruction captured in 1 cycle.
REQ-034 Flush: flush=1 with in_valid=1, out_ready=1 -> next cycle out_valid=0, ex_RegWrite=0; flush=1 with out_ready=0, out_valid=1 -> held instruction unchanged.
REQ-035 Bypass (WB_BYPASS_EN): WB_RegWr=1, WB_RW=7, WB_BusW=0xDEAD, RA=7, BusA=0x0 -> ex_A=0xDEAD; WB_RW=0 -> ex_A=BusA; macro undefined -> ex_A=0x0.
